// File: rtl/sdr_fir_pkg.sv
// ----------------------------------------------------------------------------
// sdr_fir_pkg
// Shared constants for the CIC compensation FIR: default widths, the FSM
// state enum and the Q1.15 coefficient table.
// No ports (package).
//
// COEF is a 32-tap symmetric lowpass with a mild high-frequency lift to undo
// CIC passband droop. The taps sum to 32768, so the DC gain is exactly 1.
// Symmetry (COEF[k] == COEF[31-k]) lets the optional folded MAC build
// (CIC_COMP_SYMMETRIC_EN) produce results bit-identical to the full MAC.
// ----------------------------------------------------------------------------
package sdr_fir_pkg;

    localparam int FIR_NTAPS     = 32;
    localparam int FIR_COEF_W    = 16;
    localparam int FIR_ACC_W     = 30;
    localparam int FIR_OUT_SHIFT = 15;
    localparam int SAMPLE_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } fir_state_e;

    localparam logic signed [FIR_COEF_W-1:0] COEF [0:FIR_NTAPS-1] = '{
        -16'sd40,   -16'sd80,   -16'sd60,    16'sd40,
         16'sd200,   16'sd320,   16'sd200,  -16'sd240,
        -16'sd720,  -16'sd800,  -16'sd80,    16'sd1400,
         16'sd2760,  16'sd2800,  16'sd4800,  16'sd5884,
         16'sd5884,  16'sd4800,  16'sd2800,  16'sd2760,
         16'sd1400, -16'sd80,   -16'sd800,  -16'sd720,
        -16'sd240,   16'sd200,   16'sd320,   16'sd200,
         16'sd40,   -16'sd60,   -16'sd80,   -16'sd40
    };

endpackage

// File: rtl/fir_sample_buf.sv
// ----------------------------------------------------------------------------
// fir_sample_buf
// Circular sample history for the compensation FIR. Writes land at the
// internal write pointer, which then advances modulo DEPTH. Reads are
// combinational and addressed by age: offset 0 is the newest sample.
// Optional macro: CIC_COMP_SYMMETRIC_EN adds a second read port so the
// folded MAC can fetch both mirrored taps in one cycle.
//
// Ports:
//   clk        in   system clock
//   clr        in   synchronous clear (history and pointer to 0)
//   wr_en      in   write wr_data and advance the pointer
//   wr_data    in   signed sample
//   rd_off_a   in   age of sample on read port A
//   rd_data_a  out  sample on read port A
//   rd_off_b   in   age of sample on read port B (symmetric build only)
//   rd_data_b  out  sample on read port B (symmetric build only)
// ----------------------------------------------------------------------------
module fir_sample_buf
    import sdr_fir_pkg::*;
#(
    parameter int DEPTH = FIR_NTAPS,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic signed [SAMPLE_W-1:0] wr_data,
    input  logic        [PTR_W-1:0]    rd_off_a,
    output logic signed [SAMPLE_W-1:0] rd_data_a,
`ifdef CIC_COMP_SYMMETRIC_EN
    input  logic        [PTR_W-1:0]    rd_off_b,
    output logic signed [SAMPLE_W-1:0] rd_data_b,
`endif
    input  logic                       unused_tie_lo
);

    logic signed [SAMPLE_W-1:0] mem_q [DEPTH];
    logic signed [SAMPLE_W-1:0] mem_d [DEPTH];
    logic        [PTR_W-1:0]    wr_ptr_q;
    logic        [PTR_W-1:0]    wr_ptr_d;
    logic        [PTR_W-1:0]    rd_addr_a;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en && !unused_tie_lo) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Newest sample sits one slot behind the write pointer; the subtraction
    // wraps naturally because DEPTH is a power of two.
    assign rd_addr_a = wr_ptr_q - PTR_W'(1) - rd_off_a;
    assign rd_data_a = mem_q[rd_addr_a];

`ifdef CIC_COMP_SYMMETRIC_EN
    logic [PTR_W-1:0] rd_addr_b;
    assign rd_addr_b = wr_ptr_q - PTR_W'(1) - rd_off_b;
    assign rd_data_b = mem_q[rd_addr_b];
`endif

endmodule

// File: rtl/cic_comp_fir.sv
// ----------------------------------------------------------------------------
// cic_comp_fir
// Decimate-by-2 CIC droop-compensation FIR. Detects each new CIC sample from
// the rising edge of the level-style in_clk, stores it in a circular history,
// and on every second sample runs a serial MAC over the coefficient table,
// then rounds (half-up), saturates to 8 bits and emits one sample.
// Optional macro: CIC_COMP_SYMMETRIC_EN folds the MAC over the symmetric
// coefficients (NTAPS/2 cycles instead of NTAPS); results are identical.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   in_clk     in   CIC sample clock (level, same clock domain)
//   d_in       in   signed CIC sample, valid when in_clk first seen high
//   d_out      out  signed filtered sample, held until the next result
//   out_valid  out  one-cycle pulse when d_out updates
//   overrun    out  sticky: a sample arrived while a computation was running
//
// State  | meaning
// IDLE   | waiting for samples; stores them, starts MAC on every 2nd one
// MAC    | one tap per cycle into acc, tap index k_q
// ROUND  | round, saturate, load d_out, pulse out_valid
//
// The coefficient table in sdr_fir_pkg is fixed at 32 taps; NTAPS/COEF_W
// must match it.
// ----------------------------------------------------------------------------
module cic_comp_fir
    import sdr_fir_pkg::*;
#(
    parameter int NTAPS     = FIR_NTAPS,
    parameter int COEF_W    = FIR_COEF_W,
    parameter int ACC_W     = FIR_ACC_W,
    parameter int OUT_SHIFT = FIR_OUT_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_clk,
    input  logic signed [SAMPLE_W-1:0] d_in,
    output logic signed [SAMPLE_W-1:0] d_out,
    output logic                       out_valid,
    output logic                       overrun
);

    localparam int PTR_W = $clog2(NTAPS);
    localparam int PRE_W = SAMPLE_W + 1;
`ifdef CIC_COMP_SYMMETRIC_EN
    localparam int MAC_LEN = NTAPS / 2;
`else
    localparam int MAC_LEN = NTAPS;
`endif
    localparam logic        [PTR_W-1:0]    LAST_K   = PTR_W'(MAC_LEN - 1);
    localparam logic signed [ACC_W-1:0]    RND_HALF = ACC_W'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0]    SAT_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0]    SAT_MIN  = ACC_W'(-128);
    localparam logic signed [SAMPLE_W-1:0] OUT_MAX  = 8'sh7F;
    localparam logic signed [SAMPLE_W-1:0] OUT_MIN  = 8'sh80;

    fir_state_e                 state_q, state_d;
    logic                       in_clk_q, in_clk_d;
    logic                       phase_q, phase_d;
    logic        [PTR_W-1:0]    k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] d_out_q, d_out_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overrun_q, overrun_d;

    logic                       sample_evt;
    logic                       buf_wr_en;
    logic signed [SAMPLE_W-1:0] x_a;
    logic signed [COEF_W-1:0]   coef_k;
    logic signed [ACC_W-1:0]    prod;
    logic signed [ACC_W-1:0]    rnd_sum;
    logic signed [ACC_W-1:0]    rnd_shr;
    logic signed [SAMPLE_W-1:0] sat_val;

    assign coef_k = COEF[k_q];

`ifdef CIC_COMP_SYMMETRIC_EN
    logic signed [SAMPLE_W-1:0] x_b;
    logic        [PTR_W-1:0]    off_b;
    logic signed [PRE_W-1:0]    pre_sum;

    // Mirror tap of k is NTAPS-1-k; pre-add in 9 bits so it cannot wrap.
    assign off_b   = PTR_W'(NTAPS - 1) - k_q;
    assign pre_sum = PRE_W'(x_a) + PRE_W'(x_b);
    assign prod    = ACC_W'(pre_sum) * ACC_W'(coef_k);

    fir_sample_buf #(
        .DEPTH (NTAPS),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk           (clk),
        .clr           (rst),
        .wr_en         (buf_wr_en),
        .wr_data       (d_in),
        .rd_off_a      (k_q),
        .rd_data_a     (x_a),
        .rd_off_b      (off_b),
        .rd_data_b     (x_b),
        .unused_tie_lo (1'b0)
    );
`else
    assign prod = ACC_W'(x_a) * ACC_W'(coef_k);

    fir_sample_buf #(
        .DEPTH (NTAPS),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk           (clk),
        .clr           (rst),
        .wr_en         (buf_wr_en),
        .wr_data       (d_in),
        .rd_off_a      (k_q),
        .rd_data_a     (x_a),
        .unused_tie_lo (1'b0)
    );
`endif

    // Round half-up, arithmetic shift, then clamp (never wrap).
    assign rnd_sum = acc_q + RND_HALF;
    assign rnd_shr = rnd_sum >>> OUT_SHIFT;

    always_comb begin
        if (rnd_shr > SAT_MAX) begin
            sat_val = OUT_MAX;
        end else if (rnd_shr < SAT_MIN) begin
            sat_val = OUT_MIN;
        end else begin
            sat_val = rnd_shr[SAMPLE_W-1:0];
        end
    end

    assign sample_evt = in_clk && !in_clk_q;

    always_comb begin
        state_d     = state_q;
        in_clk_d    = in_clk;
        phase_d     = phase_q;
        k_d         = k_q;
        acc_d       = acc_q;
        d_out_d     = d_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        buf_wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_evt) begin
                    buf_wr_en = 1'b1;
                    phase_d   = ~phase_q;
                    if (phase_q) begin
                        state_d = MAC;
                        k_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            MAC: begin
                // Samples arriving mid-computation are dropped, not queued.
                if (sample_evt) begin
                    overrun_d = 1'b1;
                end
                acc_d = acc_q + prod;
                k_d   = k_q + PTR_W'(1);
                if (k_q == LAST_K) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (sample_evt) begin
                    overrun_d = 1'b1;
                end
                d_out_d     = sat_val;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_clk_q    <= 1'b0;
            phase_q     <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_clk_q    <= in_clk_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign d_out     = d_out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// ----------------------------------------------------------------------------
// tb_cic_comp_fir
// Directed bench for cic_comp_fir: reset, impulse, DC, saturation, overrun
// and reset in the middle of a computation. Expected outputs come from the
// bench's own coefficient table and a direct convolution, plus hand-computed
// impulse values.
// ----------------------------------------------------------------------------
module tb_cic_comp_fir;

    localparam int NT = 32;
`ifdef CIC_COMP_SYMMETRIC_EN
    localparam int LAT = NT / 2 + 1;
`else
    localparam int LAT = NT + 1;
`endif

    localparam int COEF_TB [NT] = '{
        -40,  -80,  -60,   40,  200,  320,  200, -240,
       -720, -800,  -80, 1400, 2760, 2800, 4800, 5884,
       5884, 4800, 2800, 2760, 1400,  -80, -800, -720,
       -240,  200,  320,  200,   40,  -60,  -80,  -40
    };

    // round-half-up(127*COEF[odd]/2^15) for COEF[1],[3],...,[31], then 0
    localparam int IMP_EXP [17] = '{0, 0, 1, -1, -3, 5, 11, 23, 19, 11, 0, -3, 1, 1, 0, 0, 0};

    logic              clk;
    logic              rst;
    logic              in_clk;
    logic signed [7:0] d_in;
    logic signed [7:0] d_out;
    logic              out_valid;
    logic              overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_smp    = 0;
    int hist[$];
    int exp_q[$];
    int ecyc_q[$];
    int got_q[$];
    int mon_exp;
    int mon_ecyc;

    cic_comp_fir dut (
        .clk       (clk),
        .rst       (rst),
        .in_clk    (in_clk),
        .d_in      (d_in),
        .d_out     (d_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_out();
        longint s = 0;
        for (int k = 0; k < NT; k++) begin
            if (k < hist.size()) s += longint'(hist[k]) * longint'(COEF_TB[k]);
        end
        s = (s + 64'sd16384) >>> 15;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    // Output monitor: every out_valid must match the next expected result,
    // at exactly LAT cycles after the capturing edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_ecyc = ecyc_q.pop_front();
                chk("d_out", d_out, mon_exp);
                chk("latency", cyc - mon_ecyc, LAT);
                got_q.push_back(d_out);
            end
        end
    end

    // One sample event; spacing is clk cycles until the next event.
    task automatic send(input int v, input int spacing, input bit drop);
        @(negedge clk);
        in_clk = 1'b1;
        d_in   = 8'(v);
        @(posedge clk);
        #2;
        if (!drop) begin
            hist.push_front(v);
            n_smp++;
            if (n_smp % 2 == 0) begin
                exp_q.push_back(model_out());
                ecyc_q.push_back(cyc);
            end
        end
        @(negedge clk);
        in_clk = 1'b0;
        repeat (spacing - 2) @(negedge clk);
    endtask

    task automatic do_reset();
        exp_q.delete();
        ecyc_q.delete();
        hist.delete();
        got_q.delete();
        n_smp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst    = 1'b1;
            in_clk = (i % 2 == 0);
            d_in   = 8'sd55;
            @(posedge clk);
            #2;
            chk("rst_d_out", d_out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_overrun", overrun, 0);
        end
        @(negedge clk);
        rst    = 1'b0;
        in_clk = 1'b0;
        d_in   = '0;
    endtask

    initial begin
        rst    = 1'b1;
        in_clk = 1'b0;
        d_in   = '0;
        do_reset();

        // Impulse
        send(127, 64, 1'b0);
        for (int i = 0; i < 33; i++) send(0, 64, 1'b0);
        chk("imp_count", got_q.size(), 17);
        for (int i = 0; i < 17 && i < got_q.size(); i++) begin
            chk($sformatf("imp_%0d", i), got_q[i], IMP_EXP[i]);
        end

        // DC at minimum spacing
        got_q.delete();
        for (int i = 0; i < 40; i++) send(64, NT + 2, 1'b0);
        repeat (40) @(negedge clk);
        chk("dc_count", got_q.size(), 20);
        for (int j = 15; j < 20 && j < got_q.size(); j++) begin
            chk("dc_level", got_q[j], 64);
        end
        chk("dc_overrun", overrun, 0);

        // Saturation, positive then negative
        do_reset();
        for (int i = 0; i < NT; i++) send(COEF_TB[NT-1-i] > 0 ? 127 : -127, 40, 1'b0);
        chk("sat_hi_count", got_q.size(), 16);
        if (got_q.size() > 0) chk("sat_hi", got_q[$], 127);
        do_reset();
        for (int i = 0; i < NT; i++) send(COEF_TB[NT-1-i] > 0 ? -127 : 127, 40, 1'b0);
        chk("sat_lo_count", got_q.size(), 16);
        if (got_q.size() > 0) chk("sat_lo", got_q[$], -128);

        // Overrun: third sample lands 10 cycles into the MAC and is dropped
        do_reset();
        send(60, 40, 1'b0);
        send(50, 10, 1'b0);
        chk("ovr_before", overrun, 0);
        send(100, 60, 1'b1);
        chk("ovr_set", overrun, 1);
        for (int i = 0; i < 14; i++) send(0, 40, 1'b0);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_count", got_q.size(), 8);
        if (got_q.size() > 0) chk("ovr_last", got_q[$], 18);

        // Reset while the MAC is at tap 5
        send(120, 40, 1'b0);
        send(120, 6, 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) send(0, 40, 1'b0);
        chk("midrst_count", got_q.size(), 8);
        if (got_q.size() > 0) chk("midrst_last", got_q[$], 0);
        chk("midrst_overrun", overrun, 0);

        repeat (50) @(negedge clk);
        chk("no_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimate-by-2 compensation FIR that consumes the 8-bit CIC decimator output stream and flattens the CIC passband droop. It sits directly downstream of the CIC, in the same `clk` domain. It detects each new sample from the CIC's level-style sample clock and runs one serial multiply-accumulate per tap. It emits one rounded, saturated 8-bit sample per two input samples, toward the demodulator.

## Interface
- `NTAPS`, 32: filter length; even, power of two, 8..64.
- `COEF_W`, 16: signed coefficient width, Q1.15.
- `ACC_W`, 30: accumulator width; must be ≥ 8 + `COEF_W` + log2(`NTAPS`).
- `OUT_SHIFT`, 15: right shift applied to the accumulator before saturation.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `in_clk`, in, 1: CIC sample clock (level). A new sample is present when a rising edge is detected.
- `d_in`, in, 8: signed CIC output sample. Valid in the cycle `in_clk` is first seen high.
- `d_out`, out, 8: signed filtered sample. Held until the next result.
- `out_valid`, out, 1: one-cycle pulse, asserted in the same cycle `d_out` updates.
- `overrun`, out, 1: sticky flag; a sample arrived while the MAC was busy.

## Operation
- Edge detect: register `in_clk_q`. A sample event occurs when `in_clk && !in_clk_q`. No synchroniser, because the input is in the same domain.
- Sample buffer: `NTAPS`×8 circular register array with write pointer `wr_ptr`.
  - On a sample event in IDLE, write `d_in` at `wr_ptr`, increment `wr_ptr` (modulo `NTAPS`), and toggle `phase`.
- States:
  - IDLE → MAC on a sample event that toggles `phase` from 1 to 0, i.e. every second sample. Otherwise stay in IDLE.
  - MAC: tap index k runs 0..`NTAPS`-1, one tap per cycle. Each cycle does `acc += COEF[k] * x[n-k]`, where x[n] is the newest sample. The accumulator is cleared when MAC is entered. After the last tap → ROUND.
  - ROUND: `r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT`, arithmetic. Saturate to [-128, 127], load `d_out`, pulse `out_valid` → IDLE.
- Arithmetic: signed 8×16 products, sign-extended to `ACC_W`. Rounding is round-half-up; saturation is a clamp, never a wrap.
- The first output is produced at the 2nd sample after reset. Buffer slots never written since reset read as 0.
- Overrun: a sample event in MAC or ROUND is dropped. It is not written and `phase` does not change. `overrun` is set to 1 and stays at 1 until `rst`. The computation in progress completes unaffected.

## Timing
- Reset values: `d_out`=0, `out_valid`=0, `overrun`=0, `in_clk_q`=0, `phase`=0, `wr_ptr`=0, buffer all 0, state IDLE, `acc`=0.
- Latency: the capturing edge is E, the second sample of a pair. MAC occupies edges E+1..E+`NTAPS`. ROUND is at E+`NTAPS`+1, where `d_out` and `out_valid` update. `out_valid` is high for exactly one cycle. Latency is 33 cycles at `NTAPS`=32.
- Minimum input spacing without overrun: `NTAPS`+2 clk cycles between sample events. A CIC with decimation ratio ≥ 64 always meets this.
- Reset mid-MAC: the state returns to IDLE and no `out_valid` is issued for the aborted computation. All state and the buffer clear.
- A sample event in the same cycle as `rst` is ignored.
- `wr_ptr` wraps from `NTAPS`-1 to 0. The tap read address is `(wr_ptr - 1 - k) mod NTAPS`.

## Configuration
- `CIC_COMP_SYMMETRIC_EN` defined: coefficients are treated as symmetric. MAC pre-adds `x[n-k] + x[n-NTAPS+1+k]` as 9-bit values and multiplies by `COEF[k]`, for k = 0..`NTAPS`/2-1.
  - MAC lasts `NTAPS`/2 cycles, so latency is `NTAPS`/2+1 cycles and minimum spacing is `NTAPS`/2+2.
- Undefined: full `NTAPS`-cycle MAC, as described above.
- `d_out` values are bit-identical in both builds.

## Structure
- Package `sdr_fir_pkg` holds:
  - `COEF[0:NTAPS-1]`, a symmetric Q1.15 inverse-sinc lowpass table whose sum is 32768 (DC gain 1).
  - Width constants and the state enum `{IDLE, MAC, ROUND}`.
- Sub-module `fir_sample_buf`: circular buffer with write port, pointer, synchronous clear, and combinational read by offset.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_clk` toggling → `d_out`=0, `out_valid`=0, `overrun`=0 throughout.
- Impulse: after reset, send sample 127 then zeros, with events every 64 cycles → the output sequence is `sat(round(127*COEF[1]/2^15))`, then `COEF[3]`, `COEF[5]`, … scaled the same way, then 0.
- DC: constant 64 for ≥ 40 samples → `d_out`=64 on every `out_valid` once the buffer is full. `out_valid` comes 33 cycles after every second event.
- Saturation: load `x[n-k] = 127*sign(COEF[k])` → `d_out`=127 (clamped). With the signs negated → -128.
- Overrun: second event 10 cycles into MAC → that sample is absent from the buffer, `overrun`=1 and sticky, and the current `d_out` equals the no-overrun value.
- Reset mid-MAC at tap 5 → no `out_valid`. The next output uses only post-reset samples, which matches a fresh-start model.
